qdiv_sched: RTL

Round-robin scheduler that shares one `qdiv` Q15.16 sign-magnitude divider among N requesters. It accepts one division job at a time through a valid/ready handshake, drives and holds the divider operands, and waits for a trustworthy `valid`. It returns the quotient to the granting port as a one-cycle response. Zero divisors and divider hangs are handled locally, so the divider's sticky `warn` is never relied on.

---
 rtl/qdiv_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/qdiv_sched.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/qdiv_pkg.sv
// Shared constants and FSM encoding for the Q15.16 divider scheduler.
package qdiv_pkg;

  localparam int QW     = 32;
  localparam int QFBITS = 16;
  localparam int QSIGN  = 31;

  localparam logic [QW-1:0] Q_ONE = 32'h0000_0001 << QFBITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin picker: lowest requesting index at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] j_s;
  logic          found_s;
  logic          hit_s;

  // scan from ptr_i upward; the first hit wins and masks every later index
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    j_s     = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int off = 0; off < N; off++) begin
      j_s        = IW'((int'(ptr_i) + off) % N);
      hit_s      = req_i[j_s] & ~found_s;
      gnt_o[j_s] = hit_s;
      idx_o      = hit_s ? j_s : idx_o;
      found_s    = found_s | req_i[j_s];
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/qdiv_sched.sv
// Round-robin scheduler sharing one Q15.16 sign-magnitude divider among N requesters.
module qdiv_sched
  import qdiv_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 64,
  parameter int SETTLE  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*QW-1:0] req_dividend,
  input  logic [N*QW-1:0] req_divisor,
  output logic [N-1:0]    resp_valid,
  output logic [QW-1:0]   resp_quotient,
  output logic            resp_err,
  output logic [QW-1:0]   div_dividend,
  output logic [QW-1:0]   div_divisor,
  input  logic [QW-1:0]   div_quotient,
  input  logic            div_valid,
  output logic            busy
);

  localparam int IW   = $clog2(N);
  localparam int CMAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int CW   = $clog2(CMAX + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [QW-1:0]   div_dividend_q, div_dividend_d;
  logic [QW-1:0]   div_divisor_q, div_divisor_d;
  logic [N-1:0]    resp_valid_q, resp_valid_d;
  logic [QW-1:0]   resp_quotient_q, resp_quotient_d;
  logic            resp_err_q, resp_err_d;

  logic [N-1:0]    arb_gnt_s;
  logic [IW-1:0]   arb_idx_s;
  logic            arb_any_s;
  logic [QW-1:0]   sel_dividend_s;
  logic [QW-1:0]   sel_divisor_s;
  logic [N-1:0]    grant_oh_s;

  rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt_s),
    .idx_o (arb_idx_s),
    .any_o (arb_any_s)
  );

  // operand mux for the port the arbiter is offering to accept
  always_comb begin
    sel_dividend_s = '0;
    sel_divisor_s  = '0;
    for (int i = 0; i < N; i++) begin
      sel_dividend_s = (arb_idx_s == IW'(i)) ? req_dividend[QW*i +: QW] : sel_dividend_s;
      sel_divisor_s  = (arb_idx_s == IW'(i)) ? req_divisor[QW*i +: QW]  : sel_divisor_s;
    end
  end

  assign grant_oh_s = {{(N-1){1'b0}}, 1'b1} << grant_q;

  // next-state logic; response registers are loaded on entry to RESP and cleared otherwise
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    grant_d         = grant_q;
    cnt_d           = cnt_q;
    div_dividend_d  = div_dividend_q;
    div_divisor_d   = div_divisor_q;
    resp_valid_d    = '0;
    resp_quotient_d = '0;
    resp_err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any_s) begin
          grant_d = arb_idx_s;
          // zero divisor never reaches the divider, so its operands stay put
          if (sel_divisor_s[QSIGN-1:0] == 31'd0) begin
            state_d      = ST_RESP;
            resp_valid_d = arb_gnt_s;
            resp_err_d   = 1'b1;
          end else begin
            div_dividend_d = sel_dividend_s;
            div_divisor_d  = sel_divisor_s;
            cnt_d          = '0;
            state_d        = ST_SETTLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT: begin
        if (div_valid) begin
          state_d         = ST_RESP;
          resp_valid_d    = grant_oh_s;
          resp_quotient_d = div_quotient;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d      = ST_RESP;
          resp_valid_d = grant_oh_s;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: begin
        ptr_d   = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      ptr_q           <= '0;
      grant_q         <= '0;
      cnt_q           <= '0;
      div_dividend_q  <= '0;
      div_divisor_q   <= Q_ONE;
      resp_valid_q    <= '0;
      resp_quotient_q <= '0;
      resp_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      grant_q         <= grant_d;
      cnt_q           <= cnt_d;
      div_dividend_q  <= div_dividend_d;
      div_divisor_q   <= div_divisor_d;
      resp_valid_q    <= resp_valid_d;
      resp_quotient_q <= resp_quotient_d;
      resp_err_q      <= resp_err_d;
    end
  end

  assign req_ready     = (state_q == ST_IDLE) ? arb_gnt_s : '0;
  assign resp_valid    = resp_valid_q;
  assign resp_quotient = resp_quotient_q;
  assign resp_err      = resp_err_q;
  assign div_dividend  = div_dividend_q;
  assign div_divisor   = div_divisor_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
